// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: host<->controller bundle (start/pause/abort/tc in, count/busy/done/state out); master=host, slave=controller
interface count_seq_ctrl_if #(parameter int WIDTH = 4);
  logic start;
  logic pause;
  logic abort;
  logic [WIDTH-1:0] tc;
  logic [WIDTH-1:0] count;
  logic busy;
  logic done;
  logic [1:0] state;
  modport master (output start, pause, abort, tc, input count, busy, done, state);
  modport slave (input start, pause, abort, tc, output count, busy, done, state);
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: one-shot interval timer sequencer over a WIDTH-bit counter; ports clk, reset (sync, active-high), bus (slave: start/pause/abort/tc -> count/busy/done/state); define AUTO_RELOAD_EN to make DONE restart the run periodically
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  count_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, tc_q, tc_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q <= tc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d = tc_q;
    case (state_q)
      IDLE: begin
        state_d = bus.start ? RUN : IDLE;
        count_d = bus.start ? '0 : count_q;
        tc_d = bus.start ? bus.tc : tc_q;
      end
      RUN: begin
        state_d = bus.abort ? IDLE : bus.pause ? HOLD : (count_q == tc_q) ? DONE : RUN;
        count_d = bus.abort ? '0 : (bus.pause || count_q == tc_q) ? count_q : count_q + 1'b1;
      end
      HOLD: begin
        state_d = bus.abort ? IDLE : bus.pause ? HOLD : RUN;
        count_d = bus.abort ? '0 : count_q;
      end
      DONE: begin
`ifdef AUTO_RELOAD_EN
        state_d = bus.abort ? IDLE : RUN;
        count_d = '0;
`else
        state_d = IDLE;
        count_d = bus.abort ? '0 : count_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.count = count_q;
  assign bus.busy = (state_q == RUN) || (state_q == HOLD);
  assign bus.done = (state_q == DONE);
  assign bus.state = state_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed self-checking bench for count_seq_ctrl
module tb_count_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  count_seq_ctrl_if #(.WIDTH(4)) bus ();
  count_seq_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_st(input string tag, input logic [1:0] st, input logic [3:0] cnt);
    chk({tag, ".state"}, {6'd0, bus.state}, {6'd0, st});
    chk({tag, ".count"}, {4'd0, bus.count}, {4'd0, cnt});
    chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, (st == 2'b01 || st == 2'b10)});
    chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, (st == 2'b11)});
  endtask
  initial begin
    bus.start = 1'b1;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.tc = 4'd5;
    reset = 1'b1;
    step();
    expect_st("rst0", 2'b00, 4'd0);
    step();
    expect_st("rst1", 2'b00, 4'd0);
    reset = 1'b0;
`ifdef AUTO_RELOAD_EN
    bus.tc = 4'd2;
    step();
    expect_st("ar_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step();
      expect_st("ar_c1", 2'b01, 4'd1);
      step();
      expect_st("ar_c2", 2'b01, 4'd2);
      step();
      expect_st("ar_done", 2'b11, 4'd2);
      step();
      expect_st("ar_reload", 2'b01, 4'd0);
    end
    step();
    bus.abort = 1'b1;
    step();
    expect_st("ar_abort", 2'b00, 4'd0);
    bus.abort = 1'b0;
`else
    step();
    expect_st("os_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    bus.tc = 4'd9;
    for (int n = 1; n <= 5; n++) begin
      bus.start = (n == 3);
      step();
      expect_st("os_run", 2'b01, n[3:0]);
    end
    bus.start = 1'b0;
    step();
    expect_st("os_done", 2'b11, 4'd5);
    step();
    expect_st("os_idle", 2'b00, 4'd5);
    step();
    expect_st("os_idle_hold", 2'b00, 4'd5);
    bus.start = 1'b1;
    bus.tc = 4'd0;
    step();
    expect_st("tc0_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    step();
    expect_st("tc0_done", 2'b11, 4'd0);
    step();
    expect_st("tc0_idle", 2'b00, 4'd0);
    bus.start = 1'b1;
    bus.tc = 4'd15;
    step();
    expect_st("tc15_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      step();
      expect_st("tc15_run", 2'b01, n[3:0]);
    end
    step();
    expect_st("tc15_done", 2'b11, 4'd15);
    step();
    expect_st("tc15_idle", 2'b00, 4'd15);
    bus.start = 1'b1;
    bus.tc = 4'd4;
    step();
    expect_st("pz_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    step();
    expect_st("pz_c1", 2'b01, 4'd1);
    step();
    expect_st("pz_c2", 2'b01, 4'd2);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_st("pz_hold", 2'b10, 4'd2);
    end
    bus.pause = 1'b0;
    step();
    expect_st("pz_resume", 2'b01, 4'd2);
    step();
    expect_st("pz_c3", 2'b01, 4'd3);
    step();
    expect_st("pz_c4", 2'b01, 4'd4);
    step();
    expect_st("pz_done", 2'b11, 4'd4);
    step();
    expect_st("pz_idle", 2'b00, 4'd4);
    bus.start = 1'b1;
    bus.tc = 4'd1;
    step();
    expect_st("pt_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    step();
    expect_st("pt_c1", 2'b01, 4'd1);
    bus.pause = 1'b1;
    step();
    expect_st("pt_hold", 2'b10, 4'd1);
    bus.pause = 1'b0;
    step();
    expect_st("pt_resume", 2'b01, 4'd1);
    step();
    expect_st("pt_done", 2'b11, 4'd1);
    bus.abort = 1'b1;
    step();
    expect_st("ab_done", 2'b00, 4'd0);
    bus.abort = 1'b0;
    bus.start = 1'b1;
    bus.tc = 4'd6;
    step();
    expect_st("ab_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      expect_st("ab_run", 2'b01, n[3:0]);
    end
    bus.abort = 1'b1;
    bus.pause = 1'b1;
    step();
    expect_st("ab_abort_pause", 2'b00, 4'd0);
    bus.pause = 1'b0;
    step();
    expect_st("ab_idle_ign", 2'b00, 4'd0);
    bus.start = 1'b1;
    bus.tc = 4'd3;
    step();
    expect_st("ab_start_wins", 2'b01, 4'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();
    expect_st("ah_c1", 2'b01, 4'd1);
    bus.pause = 1'b1;
    step();
    expect_st("ah_hold", 2'b10, 4'd1);
    bus.abort = 1'b1;
    step();
    expect_st("ah_abort", 2'b00, 4'd0);
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    bus.start = 1'b1;
    bus.tc = 4'd7;
    step();
    expect_st("mr_start", 2'b01, 4'd0);
    bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      expect_st("mr_run", 2'b01, n[3:0]);
    end
    reset = 1'b1;
    step();
    expect_st("mr_reset", 2'b00, 4'd0);
    reset = 1'b0;
    bus.start = 1'b1;
    bus.tc = 4'd0;
    step();
    expect_st("mr_restart", 2'b01, 4'd0);
    bus.start = 1'b0;
    step();
    expect_st("mr_done", 2'b11, 4'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
